spirom_bus_ctrl: RTL and testbench
==================================

Name: spirom_bus_ctrl

Overview:
- Zorro III slave-side cycle controller for the SPI boot-ROM window.
- Sits directly upstream of the SPI ROM engine:
  - decodes bus cycles against the autoconfigured ROM base;
  - latches the longword address and the write byte, then raises romcycle;
  - waits for the engine's dtack, captures the read byte onto the bus data lanes and returns bus DTACK.
- Adds a watchdog so a hung SPI transfer cannot lock the bus.

Parameters:
- TIMEOUT, 1023: clk cycles allowed in WAIT_SPI before a forced termination. Range 128..65535; the counter is 16 bits.
- SYNC_STAGES, 2: flip-flop depth for the FCS_n, DOE and DS_n synchronisers. Value is 2 or 3.

Ports:
- clk  in  1  system clock.
- IORST  in  1  asynchronous, active-high reset.
- FCS_n  in  1  Zorro full-cycle strobe, asynchronous.
- addr_bus  in  30  bus address [31:2], valid while FCS_n is low.
- rom_base  in  9  configured base, compared against addr_bus[31:23].
- configured  in  1  autoconfig complete; when low, no decode.
- READ  in  1  bus direction, 1 = read.
- DOE  in  1  bus data output enable, asynchronous.
- DS_n  in  4  byte strobes, active low; [3] = D31:24.
- data_in  in  32  bus write data.
- spi_dtack  in  1  transfer-complete indication from the SPI ROM engine.
- spi_dataout  in  8  read byte from the SPI ROM engine.
- romcycle  out  1  ROM cycle request to the engine.
- addr  out  21  latched addr_bus[22:2].
- spi_datain  out  8  latched write byte.
- data_out  out  32  bus read data.
- data_oe  out  1  drive enable for data_out.
- rom_dtack  out  1  bus DTACK, active high.
- timeout_flag  out  1  sticky; set on a watchdog expiry.

Behaviour:
- Reset: all outputs are 0, the counter is 0 and the state is IDLE. Reset asserted mid-cycle aborts immediately; the engine sees romcycle fall on the same edge.
- Synchronisers: fcs_s = ~FCS_n, doe_s = DOE, ds_s = ~DS_n, each through SYNC_STAGES flops. All decisions use the synchronised values.
- IDLE:
  - On fcs_s rising, sample addr_bus and data_in directly; they are stable by then.
  - If configured && addr_bus[31:23]==rom_base: latch addr <= addr_bus[22:2] and go to WSTB.
  - Otherwise go to MISS.
- MISS: no outputs change. Stay until fcs_s==0, then go to IDLE. A mismatched cycle is never re-decoded.
- WSTB:
  - If READ: go to WAIT_SPI and assert romcycle (one clk after the latch).
  - If write: wait for any ds_s bit and doe_s, then latch spi_datain from the highest active lane (priority DS 3 > 2 > 1 > 0), go to WAIT_SPI and assert romcycle.
  - If fcs_s drops first: go to IDLE.
- WAIT_SPI:
  - The counter increments every clk.
  - On spi_dtack=1: if READ, data_out <= {4{spi_dataout}}. Assert rom_dtack and go to HOLD. The data byte is replicated on all four lanes.
  - If the counter reaches TIMEOUT-1 with no dtack: data_out <= 32'hFFFFFFFF (reads only), set timeout_flag, assert rom_dtack, go to HOLD.
  - spi_dtack and timeout on the same edge: dtack wins, and timeout_flag is not set.
  - fcs_s==0 (bus abort): clear romcycle and go to IDLE.
- HOLD:
  - romcycle, rom_dtack and data_out are held.
  - data_oe = READ && doe_s && state==HOLD, registered.
  - On fcs_s==0: in the same clk edge clear romcycle, rom_dtack and data_oe, clear the counter and go to IDLE.
  - data_out keeps its last value; it is don't-care while data_oe=0.
- Back-to-back cycles: IDLE needs one clk with fcs_s==0 before it accepts a new rising edge. Edge detection uses a registered copy of fcs_s.
- romcycle is never high in IDLE or MISS.
- Latency: read dtack appears on the bus 1 clk after spi_dtack, plus SYNC_STAGES clks of FCS sync at the start.
- timeout_flag is cleared only by IORST.

Test Plan:
- Read hit:
  - Stimulus: rom_base=9'h1E0, configured=1, READ=1, addr_bus[31:2] with [31:23]=1E0 and [22:2]=21'h00123; FCS_n low; model returns spi_dataout=8'hA5 after 80 clk.
  - Required: addr=21'h00123; romcycle rises 1 clk after the latch; data_out=32'hA5A5A5A5; rom_dtack rises 1 clk after spi_dtack; data_oe=1 while DOE is high.
- Write lanes:
  - Stimulus: READ=0, DS_n=4'b1100, data_in=32'h11223344.
  - Required: spi_datain=8'h33; romcycle only after ds_s and doe_s are valid.
- Miss:
  - Stimulus: addr_bus[31:23]=1E1, or configured=0.
  - Required: romcycle, rom_dtack and data_oe stay 0 through the whole cycle; IDLE re-entered after FCS_n goes high.
- Timeout:
  - Stimulus: TIMEOUT=200, the engine never acks.
  - Required: at clk 200 in WAIT_SPI, rom_dtack=1, data_out=32'hFFFFFFFF, timeout_flag=1; the flag persists over the next good cycle.
- Abort and reset:
  - Stimulus: FCS_n released during WAIT_SPI.
  - Required: romcycle=0 and state IDLE within 1 clk after the synchroniser.
  - Stimulus: IORST pulsed in HOLD.
  - Required: all outputs 0 asynchronously.
- Simultaneous events: spi_dtack on the exact timeout clk → data_out={4{spi_dataout}}, timeout_flag stays 0.

Source files
------------

// File: rtl/spirom_bus_ctrl.sv
// Zorro III slave-side cycle controller for the SPI boot-ROM window.
// Decodes the ROM window, hands one longword cycle to the SPI engine and returns DTACK, with a watchdog.
module spirom_bus_ctrl #(
    parameter int unsigned TIMEOUT     = 1023,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        IORST,
    input  logic        FCS_n,
    input  logic [31:2] addr_bus,
    input  logic [8:0]  rom_base,
    input  logic        configured,
    input  logic        READ,
    input  logic        DOE,
    input  logic [3:0]  DS_n,
    input  logic [31:0] data_in,
    input  logic        spi_dtack,
    input  logic [7:0]  spi_dataout,
    output logic        romcycle,
    output logic [20:0] addr,
    output logic [7:0]  spi_datain,
    output logic [31:0] data_out,
    output logic        data_oe,
    output logic        rom_dtack,
    output logic        timeout_flag,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MISS = 3'd1,
        S_WSTB = 3'd2,
        S_WAIT = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t                        state_q;
    logic [SYNC_STAGES-1:0]        fcs_sync_q;
    logic [SYNC_STAGES-1:0]        doe_sync_q;
    logic [SYNC_STAGES-1:0][3:0]   ds_sync_q;
    logic                          fcs_prev_q;
    logic [15:0]                   cnt_q;
    logic [31:0]                   wdata_q;
    logic                          romcycle_q;
    logic [20:0]                   addr_q;
    logic [7:0]                    spi_datain_q;
    logic [31:0]                   data_out_q;
    logic                          data_oe_q;
    logic                          rom_dtack_q;
    logic                          timeout_q;

    logic       fcs_s;
    logic       doe_s;
    logic [3:0] ds_s;
    logic [7:0] wr_byte;

    assign fcs_s = fcs_sync_q[SYNC_STAGES-1];
    assign doe_s = doe_sync_q[SYNC_STAGES-1];
    assign ds_s  = ds_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge IORST) begin
        if (IORST) begin
            fcs_sync_q <= '0;
            doe_sync_q <= '0;
            ds_sync_q  <= '0;
        end else begin
            fcs_sync_q <= {fcs_sync_q[SYNC_STAGES-2:0], ~FCS_n};
            doe_sync_q <= {doe_sync_q[SYNC_STAGES-2:0], DOE};
            ds_sync_q  <= {ds_sync_q[SYNC_STAGES-2:0], ~DS_n};
        end
    end

    // Highest active byte lane wins; D31:24 is lane 3.
    always_comb begin
        wr_byte = wdata_q[7:0];
        if (ds_s[3])      wr_byte = wdata_q[31:24];
        else if (ds_s[2]) wr_byte = wdata_q[23:16];
        else if (ds_s[1]) wr_byte = wdata_q[15:8];
    end

    // Engine handshake: romcycle is a level request held from WAIT_SPI through HOLD; the
    // engine answers with spi_dtack, and the request only drops when the bus cycle ends.
    always_ff @(posedge clk or posedge IORST) begin
        if (IORST) begin
            state_q      <= S_IDLE;
            fcs_prev_q   <= 1'b0;
            cnt_q        <= '0;
            wdata_q      <= '0;
            romcycle_q   <= 1'b0;
            addr_q       <= '0;
            spi_datain_q <= '0;
            data_out_q   <= '0;
            data_oe_q    <= 1'b0;
            rom_dtack_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            fcs_prev_q <= fcs_s;
            case (state_q)
                S_IDLE: begin
                    romcycle_q  <= 1'b0;
                    rom_dtack_q <= 1'b0;
                    data_oe_q   <= 1'b0;
                    cnt_q       <= '0;
                    if (fcs_s && !fcs_prev_q) begin
                        wdata_q <= data_in;
                        if (configured && addr_bus[31:23] == rom_base) begin
                            addr_q  <= addr_bus[22:2];
                            state_q <= S_WSTB;
                        end else begin
                            state_q <= S_MISS;
                        end
                    end
                end
                S_MISS: begin
                    if (!fcs_s) state_q <= S_IDLE;
                end
                S_WSTB: begin
                    if (!fcs_s) begin
                        state_q <= S_IDLE;
                    end else if (READ) begin
                        romcycle_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= S_WAIT;
                    end else if ((|ds_s) && doe_s) begin
                        spi_datain_q <= wr_byte;
                        romcycle_q   <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!fcs_s) begin
                        romcycle_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                        // A real ack on the expiry clock still counts as a normal completion.
                        if (spi_dtack) begin
                            if (READ) data_out_q <= {4{spi_dataout}};
                            rom_dtack_q <= 1'b1;
                            state_q     <= S_HOLD;
                        end else if (cnt_q == CNT_LAST) begin
                            if (READ) data_out_q <= 32'hFFFF_FFFF;
                            timeout_q   <= 1'b1;
                            rom_dtack_q <= 1'b1;
                            state_q     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!fcs_s) begin
                        romcycle_q  <= 1'b0;
                        rom_dtack_q <= 1'b0;
                        data_oe_q   <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= S_IDLE;
                    end else begin
                        data_oe_q <= READ && doe_s;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign romcycle     = romcycle_q;
    assign addr         = addr_q;
    assign spi_datain   = spi_datain_q;
    assign data_out     = data_out_q;
    assign data_oe      = data_oe_q;
    assign rom_dtack    = rom_dtack_q;
    assign timeout_flag = timeout_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_spirom_bus_ctrl.sv
// Bench for spirom_bus_ctrl: directed vector table, hand sequences for abort/reset/strobe timing,
// and random bus cycles checked against a behavioural model of the ROM window.
module tb_spirom_bus_ctrl;

    localparam int TO = 200;
    localparam int SS = 2;
    localparam logic [2:0] ST_IDLE = 3'd0;

    logic        clk = 1'b0;
    logic        IORST;
    logic        FCS_n;
    logic [31:2] addr_bus;
    logic [8:0]  rom_base;
    logic        configured;
    logic        READ;
    logic        DOE;
    logic [3:0]  DS_n;
    logic [31:0] data_in;
    logic        spi_dtack;
    logic [7:0]  spi_dataout;
    logic        romcycle;
    logic [20:0] addr;
    logic [7:0]  spi_datain;
    logic [31:0] data_out;
    logic        data_oe;
    logic        rom_dtack;
    logic        timeout_flag;
    logic [2:0]  state_dbg;

    spirom_bus_ctrl #(.TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
        .clk(clk), .IORST(IORST), .FCS_n(FCS_n), .addr_bus(addr_bus), .rom_base(rom_base),
        .configured(configured), .READ(READ), .DOE(DOE), .DS_n(DS_n), .data_in(data_in),
        .spi_dtack(spi_dtack), .spi_dataout(spi_dataout), .romcycle(romcycle), .addr(addr),
        .spi_datain(spi_datain), .data_out(data_out), .data_oe(data_oe), .rom_dtack(rom_dtack),
        .timeout_flag(timeout_flag), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        rd;
        logic        cfg;
        logic [8:0]  base;
        logic [29:0] a;
        logic [3:0]  ds_n;
        logic        doe;
        logic [31:0] din;
        logic [7:0]  rbyte;
        int          d;
        logic        hit;
        logic [20:0] e_addr;
        logic [7:0]  e_byte;
        int          e_lat;
        logic [31:0] e_data;
        logic        e_to;
        logic        e_oe;
    } vec_t;

    vec_t        tbl[8];
    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_fail;
    logic        model_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural view of one bus cycle: window hit, lane choice, ack-vs-watchdog race.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.hit    = v.cfg && (v.a[29:21] == v.base);
        r.e_addr = v.a[20:0];
        r.e_byte = 8'h00;
        for (int i = 0; i < 4; i++)
            if (!v.ds_n[i]) r.e_byte = v.din[8*i +: 8];
        r.e_to   = (v.d + 1) > TO;
        r.e_lat  = r.e_to ? TO : v.d + 1;
        r.e_data = r.e_to ? 32'hFFFF_FFFF : {4{v.rbyte}};
        r.e_oe   = v.rd && v.doe;
        return r;
    endfunction

    task automatic drive_bus(input vec_t v);
        @(negedge clk);
        configured  = v.cfg;
        rom_base    = v.base;
        addr_bus    = v.a;
        READ        = v.rd;
        DS_n        = v.rd ? 4'hF : v.ds_n;
        DOE         = v.doe;
        data_in     = v.din;
        spi_dataout = v.rbyte;
        FCS_n       = 1'b0;
    endtask

    task automatic release_and_check_idle(input string tag);
        FCS_n     = 1'b1;
        spi_dtack = 1'b0;
        DS_n      = 4'hF;
        DOE       = 1'b0;
        repeat (SS + 2) @(negedge clk);
        chk({tag, "_idle_state"}, 32'(state_dbg), 32'(ST_IDLE));
        chk({tag, "_idle_outputs"}, 32'({romcycle, rom_dtack, data_oe}), 32'(0));
    endtask

    task automatic run_vec(input vec_t v);
        int          n;
        logic [20:0] prev_addr;
        logic        bad;
        drive_bus(v);
        if (v.hit) begin
            n = 0;
            prev_addr = addr;
            while (!romcycle && n < 20) begin
                prev_addr = addr;
                @(negedge clk);
                n++;
            end
            chk("romcycle_latency", 32'(n), 32'(SS + 2));
            chk("addr_latched_before_romcycle", 32'(prev_addr), 32'(v.e_addr));
            if (!v.rd) chk("spi_datain_lane", 32'(spi_datain), 32'(v.e_byte));
            if (v.rd) exp_q.push_back(v.e_data);
            n = 0;
            while (!rom_dtack && n < TO + 50) begin
                if (n == v.d) spi_dtack = 1'b1;
                @(negedge clk);
                n++;
            end
            chk("dtack_latency", 32'(n), 32'(v.e_lat));
            if (v.e_to) model_to = 1'b1;
            chk("timeout_flag", 32'(timeout_flag), 32'(model_to));
            if (v.rd && exp_q.size() > 0) chk("read_data", data_out, exp_q.pop_front());
            repeat (2) @(negedge clk);
            chk("data_oe_in_hold", 32'(data_oe), 32'(v.e_oe));
            chk("romcycle_in_hold", 32'(romcycle), 32'(1));
        end else begin
            bad = 1'b0;
            repeat (12) begin
                @(negedge clk);
                if (romcycle || rom_dtack || data_oe) bad = 1'b1;
            end
            chk("miss_outputs_quiet", 32'(bad), 32'(0));
        end
        release_and_check_idle(v.hit ? "hit" : "miss");
    endtask

    initial begin
        int   n;
        logic bad;
        vec_t v;
        n_checks = 0;
        n_fail   = 0;
        model_to = 1'b0;
        IORST = 1'b1; FCS_n = 1'b1; addr_bus = '0; rom_base = '0; configured = 1'b0;
        READ = 1'b0; DOE = 1'b0; DS_n = 4'hF; data_in = '0; spi_dtack = 1'b0; spi_dataout = '0;
        repeat (3) @(negedge clk);
        chk("reset_flags", 32'({romcycle, rom_dtack, data_oe, timeout_flag}), 32'(0));
        chk("reset_addr", 32'(addr), 32'(0));
        chk("reset_data_out", data_out, 32'(0));
        chk("reset_spi_datain", 32'(spi_datain), 32'(0));
        chk("reset_state", 32'(state_dbg), 32'(ST_IDLE));
        IORST = 1'b0;
        repeat (2) @(negedge clk);

        // rd cfg base a ds_n doe din rbyte d | hit e_addr e_byte e_lat e_data e_to e_oe
        tbl[0] = '{1'b1, 1'b1, 9'h1E0, {9'h1E0, 21'h00123}, 4'hF, 1'b1, 32'h0, 8'hA5, 80,
                   1'b1, 21'h00123, 8'h00, 81, 32'hA5A5A5A5, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 9'h1E0, {9'h1E0, 21'h1F00D}, 4'b1100, 1'b1, 32'h11223344, 8'h00, 10,
                   1'b1, 21'h1F00D, 8'h33, 11, 32'h0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 9'h1E0, {9'h1E1, 21'h00123}, 4'hF, 1'b1, 32'h0, 8'h77, 5,
                   1'b0, 21'h00123, 8'h00, 6, 32'h0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 9'h1E0, {9'h1E0, 21'h00456}, 4'hF, 1'b1, 32'h0, 8'h77, 5,
                   1'b0, 21'h00456, 8'h00, 6, 32'h0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 9'h1E0, {9'h1E0, 21'h0AAAA}, 4'hF, 1'b1, 32'h0, 8'h5A, 199,
                   1'b1, 21'h0AAAA, 8'h00, 200, 32'h5A5A5A5A, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 9'h1E0, {9'h1E0, 21'h15555}, 4'hF, 1'b1, 32'h0, 8'h12, 1000,
                   1'b1, 21'h15555, 8'h00, 200, 32'hFFFFFFFF, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 9'h1E0, {9'h1E0, 21'h00007}, 4'hF, 1'b1, 32'h0, 8'hC3, 3,
                   1'b1, 21'h00007, 8'h00, 4, 32'hC3C3C3C3, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 9'h1E0, {9'h1E0, 21'h1FFFF}, 4'hF, 1'b0, 32'h0, 8'h3C, 0,
                   1'b1, 21'h1FFFF, 8'h00, 1, 32'h3C3C3C3C, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // Write whose strobes arrive late: no request until DS and DOE are seen.
        v = tbl[1];
        v.ds_n = 4'hF; v.doe = 1'b0; v.din = 32'hDEADBEEF; v.rd = 1'b0;
        drive_bus(v);
        DS_n = 4'hF;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (romcycle) bad = 1'b1;
        end
        chk("write_waits_for_strobes", 32'(bad), 32'(0));
        DS_n = 4'b0110;
        DOE  = 1'b1;
        n = 0;
        while (!romcycle && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("write_strobe_latency", 32'(n), 32'(SS + 1));
        chk("write_lane_priority", 32'(spi_datain), 32'(8'hDE));
        spi_dtack = 1'b1;
        n = 0;
        while (!rom_dtack && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("write_dtack_latency", 32'(n), 32'(1));
        release_and_check_idle("late_write");

        // Bus abort while waiting on the engine.
        v = tbl[5];
        drive_bus(v);
        n = 0;
        while (!romcycle && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_romcycle_up", 32'(romcycle), 32'(1));
        repeat (20) @(negedge clk);
        FCS_n = 1'b1;
        repeat (SS + 1) @(negedge clk);
        chk("abort_romcycle_low", 32'(romcycle), 32'(0));
        chk("abort_state_idle", 32'(state_dbg), 32'(ST_IDLE));
        chk("abort_no_dtack", 32'(rom_dtack), 32'(0));
        repeat (3) @(negedge clk);

        for (int k = 0; k < 30; k++) begin
            v.rd    = 1'($urandom_range(0, 1));
            v.cfg   = ($urandom_range(0, 7) != 0);
            v.base  = 9'h1E0;
            v.a     = {($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'h1E0, 21'($urandom)};
            v.ds_n  = 4'($urandom_range(0, 14));
            v.doe   = v.rd ? 1'($urandom_range(0, 1)) : 1'b1;
            v.din   = $urandom;
            v.rbyte = 8'($urandom);
            v.d     = ($urandom_range(0, 9) == 0) ? int'($urandom_range(195, 260))
                                                   : int'($urandom_range(0, 40));
            run_vec(model(v));
        end

        // Asynchronous reset while holding a finished read on the bus.
        drive_bus(tbl[0]);
        n = 0;
        while (!romcycle && n < 20) begin
            @(negedge clk);
            n++;
        end
        spi_dtack = 1'b1;
        n = 0;
        while (!rom_dtack && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("pre_reset_data_oe", 32'(data_oe), 32'(1));
        #3;
        IORST     = 1'b1;
        FCS_n     = 1'b1;
        spi_dtack = 1'b0;
        #1;
        chk("async_reset_flags", 32'({romcycle, rom_dtack, data_oe, timeout_flag}), 32'(0));
        chk("async_reset_data_out", data_out, 32'(0));
        chk("async_reset_state", 32'(state_dbg), 32'(ST_IDLE));
        model_to = 1'b0;
        repeat (3) @(negedge clk);
        IORST = 1'b0;
        repeat (2) @(negedge clk);
        run_vec(tbl[6]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
